// File: rtl/jtag_ir_dr_path.sv
// JTAG instruction/data-register datapath fed by an external TAP controller.
// Provides the IR, the BYPASS/IDCODE/USER data registers and the serial TDO mux.
module jtag_ir_dr_path #(
  parameter int                  IR_WIDTH   = 4,
  parameter int                  UDR_WIDTH  = 8,
  parameter logic [31:0]         IDCODE_VAL = 32'h1000_0001,
  parameter logic [IR_WIDTH-1:0] OP_IDCODE  = IR_WIDTH'(1),
  parameter logic [IR_WIDTH-1:0] OP_USER    = IR_WIDTH'(8)
) (
  input  logic                 TCK,
  input  logic                 reset,
  input  logic [3:0]           tap_state,
  input  logic                 TDI,
  input  logic [UDR_WIDTH-1:0] udr_in,
  output logic                 TDO_data,
  output logic [IR_WIDTH-1:0]  instruction,
  output logic [UDR_WIDTH-1:0] udr_out,
  output logic                 udr_update
);

  localparam logic [3:0] ST_RESET    = 4'd0;
  localparam logic [3:0] ST_CAP_DR   = 4'd3;
  localparam logic [3:0] ST_SHIFT_DR = 4'd4;
  localparam logic [3:0] ST_UPD_DR   = 4'd8;
  localparam logic [3:0] ST_CAP_IR   = 4'd10;
  localparam logic [3:0] ST_SHIFT_IR = 4'd11;
  localparam logic [3:0] ST_UPD_IR   = 4'd15;

  // The mandatory "01" pattern loaded into the IR on capture
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);

  logic [IR_WIDTH-1:0]  r_ir_sr;
  logic [IR_WIDTH-1:0]  r_instruction;
  logic                 r_bypass;
  logic [31:0]          r_id_sr;
  logic [UDR_WIDTH-1:0] r_udr_sr;
  logic [UDR_WIDTH-1:0] r_udr_out;
  logic                 r_udr_update;

  logic                 w_sel_id;
  logic                 w_sel_user;
  logic                 w_sel_byp;
  logic [IR_WIDTH-1:0]  w_ir_shift;
  logic [UDR_WIDTH:0]   w_udr_cat;
  logic [UDR_WIDTH-1:0] w_udr_shift;

  // Anything that is neither IDCODE nor USER falls through to BYPASS
  assign w_sel_id    = (r_instruction == OP_IDCODE);
  assign w_sel_user  = (r_instruction == OP_USER);
  assign w_sel_byp   = !w_sel_id && !w_sel_user;

  assign w_ir_shift  = {TDI, r_ir_sr[IR_WIDTH-1:1]};
  assign w_udr_cat   = {TDI, r_udr_sr};
  assign w_udr_shift = w_udr_cat[UDR_WIDTH:1];

  always_ff @(posedge TCK) begin
    if (reset) begin
      r_ir_sr       <= '0;
      r_instruction <= OP_IDCODE;
    end else begin
      if (tap_state == ST_CAP_IR)        r_ir_sr <= IR_CAPTURE;
      else if (tap_state == ST_SHIFT_IR) r_ir_sr <= w_ir_shift;
      if (tap_state == ST_RESET)         r_instruction <= OP_IDCODE;
      else if (tap_state == ST_UPD_IR)   r_instruction <= r_ir_sr;
    end
  end

  always_ff @(posedge TCK) begin
    if (reset) begin
      r_bypass <= 1'b0;
      r_id_sr  <= '0;
      r_udr_sr <= '0;
    end else if (tap_state == ST_CAP_DR) begin
      if (w_sel_byp)  r_bypass <= 1'b0;
      if (w_sel_id)   r_id_sr  <= IDCODE_VAL;
      if (w_sel_user) r_udr_sr <= udr_in;
    end else if (tap_state == ST_SHIFT_DR) begin
      if (w_sel_byp)  r_bypass <= TDI;
      if (w_sel_id)   r_id_sr  <= {TDI, r_id_sr[31:1]};
      if (w_sel_user) r_udr_sr <= w_udr_shift;
    end
  end

  always_ff @(posedge TCK) begin
    if (reset) begin
      r_udr_out    <= '0;
      r_udr_update <= 1'b0;
    end else begin
      r_udr_update <= (tap_state == ST_UPD_DR) && w_sel_user;
      if ((tap_state == ST_UPD_DR) && w_sel_user) r_udr_out <= r_udr_sr;
    end
  end

  always_comb begin
    TDO_data = 1'b0;
    if (tap_state == ST_SHIFT_IR) begin
      TDO_data = r_ir_sr[0];
    end else if (tap_state == ST_SHIFT_DR) begin
      if (w_sel_id)        TDO_data = r_id_sr[0];
      else if (w_sel_user) TDO_data = r_udr_sr[0];
      else                 TDO_data = r_bypass;
    end
  end

  assign instruction = r_instruction;
  assign udr_out     = r_udr_out;
  assign udr_update  = r_udr_update;

endmodule

// File: tb/tb_jtag_ir_dr_path.sv
// Scoreboard bench for jtag_ir_dr_path: expected TDO bits are queued as each TAP
// cycle is driven and retired against the DUT output within that cycle.
module tb_jtag_ir_dr_path;

  localparam int          IR_W   = 4;
  localparam int          UDR_W  = 8;
  localparam logic [31:0] IDCODE = 32'h1000_0001;

  localparam logic [3:0] S_RESET = 4'd0,  S_IDLE  = 4'd1,  S_CAPDR = 4'd3,  S_SHDR  = 4'd4;
  localparam logic [3:0] S_EX1DR = 4'd5,  S_PSDR  = 4'd6,  S_EX2DR = 4'd7,  S_UPDR  = 4'd8;
  localparam logic [3:0] S_CAPIR = 4'd10, S_SHIR  = 4'd11, S_EX1IR = 4'd12, S_UPIR  = 4'd15;

  logic             TCK = 1'b0;
  logic             reset = 1'b1;
  logic [3:0]       tap_state = S_RESET;
  logic             TDI = 1'b0;
  logic [UDR_W-1:0] udr_in = '0;
  logic             TDO_data;
  logic [IR_W-1:0]  instruction;
  logic [UDR_W-1:0] udr_out;
  logic             udr_update;

  int   n_chk  = 0;
  int   n_fail = 0;
  logic q_tdo[$];

  jtag_ir_dr_path dut (
    .TCK        (TCK),
    .reset      (reset),
    .tap_state  (tap_state),
    .TDI        (TDI),
    .udr_in     (udr_in),
    .TDO_data   (TDO_data),
    .instruction(instruction),
    .udr_out    (udr_out),
    .udr_update (udr_update)
  );

  always #5 TCK = ~TCK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One TAP cycle: drive mid-low phase, optionally queue and retire an expected TDO bit
  task automatic step(input logic [3:0] st, input logic tdi, input logic rst_v,
                      input bit has_exp, input logic exp_tdo);
    logic e;
    @(negedge TCK);
    tap_state = st;
    TDI       = tdi;
    reset     = rst_v;
    if (has_exp) q_tdo.push_back(exp_tdo);
    #2;
    if (has_exp && q_tdo.size() > 0) begin
      e = q_tdo.pop_front();
      check("tdo", {31'd0, TDO_data}, {31'd0, e});
    end
  endtask

  task automatic load_ir(input logic [IR_W-1:0] op);
    step(S_CAPIR, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < IR_W; i++)
      step(S_SHIR, op[i], 1'b0, 1'b1, (i == 0) ? 1'b1 : 1'b0);
    step(S_EX1IR, 1'b0, 1'b0, 1'b0, 1'b0);
    step(S_UPIR, 1'b0, 1'b0, 1'b0, 1'b0);
    step(S_IDLE, 1'b0, 1'b0, 1'b1, 1'b0);
    check("ir_load", {28'd0, instruction}, {28'd0, op});
  endtask

  task automatic user_scan(input logic [UDR_W-1:0] cap, input logic [UDR_W-1:0] dat,
                           input int pause_at);
    udr_in = cap;
    step(S_CAPDR, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < UDR_W; i++) begin
      if (i == pause_at) begin
        step(S_EX1DR, 1'b1, 1'b0, 1'b1, 1'b0);
        step(S_PSDR,  1'b1, 1'b0, 1'b1, 1'b0);
        step(S_PSDR,  1'b1, 1'b0, 1'b1, 1'b0);
        step(S_EX2DR, 1'b1, 1'b0, 1'b1, 1'b0);
      end
      step(S_SHDR, dat[i], 1'b0, 1'b1, cap[i]);
    end
    step(S_EX1DR, 1'b0, 1'b0, 1'b0, 1'b0);
    step(S_UPDR, 1'b0, 1'b0, 1'b0, 1'b0);
    check("upd_pre", {31'd0, udr_update}, 32'd0);
    step(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
    check("udr_out", {24'd0, udr_out}, {24'd0, dat});
    check("upd_hi", {31'd0, udr_update}, 32'd1);
    step(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
    check("upd_lo", {31'd0, udr_update}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    step(S_RESET, 1'b0, 1'b1, 1'b1, 1'b0);
    step(S_RESET, 1'b0, 1'b1, 1'b1, 1'b0);
    check("rst_instr", {28'd0, instruction}, 32'd1);
    check("rst_udr_out", {24'd0, udr_out}, 32'd0);
    check("rst_upd", {31'd0, udr_update}, 32'd0);

    // IDCODE shifted out LSB first
    step(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
    step(S_CAPDR, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) step(S_SHDR, 1'b0, 1'b0, 1'b1, IDCODE[i]);
    step(S_EX1DR, 1'b0, 1'b0, 1'b1, 1'b0);

    // IR capture pattern, then all ones selects BYPASS
    load_ir(4'hF);

    // Bypass: one-cycle delay of TDI
    step(S_CAPDR, 1'b0, 1'b0, 1'b0, 1'b0);
    step(S_SHDR, 1'b1, 1'b0, 1'b1, 1'b0);
    step(S_SHDR, 1'b0, 1'b0, 1'b1, 1'b1);
    step(S_SHDR, 1'b1, 1'b0, 1'b1, 1'b0);
    step(S_SHDR, 1'b1, 1'b0, 1'b1, 1'b1);
    step(S_EX1DR, 1'b0, 1'b0, 1'b0, 1'b0);
    step(S_UPDR, 1'b0, 1'b0, 1'b0, 1'b0);
    step(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
    check("byp_no_upd", {31'd0, udr_update}, 32'd0);

    // USER register plain scan, then with a pause inserted after three bits
    load_ir(4'h8);
    user_scan(8'h5A, 8'hC3, -1);
    user_scan(8'h5A, 8'h3C, 3);

    // Undefined opcode behaves as bypass
    load_ir(4'h3);
    step(S_CAPDR, 1'b0, 1'b0, 1'b0, 1'b0);
    step(S_SHDR, 1'b1, 1'b0, 1'b1, 1'b0);
    step(S_SHDR, 1'b1, 1'b0, 1'b1, 1'b1);
    step(S_SHDR, 1'b0, 1'b0, 1'b1, 1'b1);
    step(S_SHDR, 1'b0, 1'b0, 1'b1, 1'b0);
    step(S_EX1DR, 1'b0, 1'b0, 1'b0, 1'b0);
    check("udr_hold", {24'd0, udr_out}, 32'h3C);

    // Reset pulsed mid IR shift clears ir_sr and restores IDCODE
    step(S_CAPIR, 1'b0, 1'b0, 1'b0, 1'b0);
    step(S_SHIR, 1'b1, 1'b0, 1'b1, 1'b1);
    step(S_SHIR, 1'b1, 1'b1, 1'b1, 1'b0);
    step(S_EX1IR, 1'b0, 1'b0, 1'b0, 1'b0);
    check("midrst_instr", {28'd0, instruction}, 32'd1);
    step(S_UPIR, 1'b0, 1'b0, 1'b0, 1'b0);
    step(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
    check("midrst_irsr", {28'd0, instruction}, 32'd0);

    // Test-Logic-Reset state restores IDCODE without the reset pin
    step(S_RESET, 1'b0, 1'b0, 1'b0, 1'b0);
    step(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
    check("tlr_instr", {28'd0, instruction}, 32'd1);
    step(S_CAPDR, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(S_SHDR, 1'b0, 1'b0, 1'b1, IDCODE[i]);
    step(S_EX1DR, 1'b0, 1'b0, 1'b0, 1'b0);

    check("queue_empty", q_tdo.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
